// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - 640x480@60 VGA timing generator and cell-map pixel fetch
//
// Purpose: walks the raster with h/v counters advanced by a pixel-rate enable,
// addresses a synchronous cell-map RAM (one read per pixel, one enabled cycle
// of latency) and presents a 5-bit palette index per pixel, time-aligned with
// hsync/vsync/de/frame_start. Blanking pixels carry index 31 (black).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset, overrides ce
//   ce           pixel-rate enable; all state holds while low
//   mem_addr     cell-map read address (0 outside the visible region)
//   mem_data     palette index from RAM, valid one enabled cycle after mem_addr
//   color        palette index to the decoder, 31 in blanking
//   hsync/vsync  active-low sync pulses
//   de           display enable, high for visible pixels
//   frame_start  high for output pixel (0,0)
module vga_pixel_fetch #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CELL_SHIFT = 4,
    parameter int ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [4:0]        mem_data,
    output logic [4:0]        color,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_CELLS = H_VISIBLE >> CELL_SHIFT;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Stage 1: attributes of the pixel whose RAM read is in flight
    logic       visible_q, hsync_raw_q, vsync_raw_q, first_pixel_q;
    // Stage 2: registered outputs
    logic [4:0] color_q;
    logic       hsync_q, vsync_q, de_q, frame_start_q;

    logic visible_c, hsync_raw_c, vsync_raw_c, first_pixel_c;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_MAX) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        visible_c     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsync_raw_c   = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vsync_raw_c   = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        first_pixel_c = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    // Address comes straight from the counters so the RAM samples it on the
    // same enabled edge that loads stage 1; it therefore only moves with ce.
    always_comb begin
        mem_addr = '0;
        if (visible_c) begin
            mem_addr = ADDR_W'(v_cnt_q >> CELL_SHIFT) * ADDR_W'(H_CELLS)
                     + ADDR_W'(h_cnt_q >> CELL_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            visible_q     <= 1'b0;
            hsync_raw_q   <= 1'b1;
            vsync_raw_q   <= 1'b1;
            first_pixel_q <= 1'b0;
            color_q       <= 5'd31;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (ce) begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            visible_q     <= visible_c;
            hsync_raw_q   <= hsync_raw_c;
            vsync_raw_q   <= vsync_raw_c;
            first_pixel_q <= first_pixel_c;
            // mem_data now answers the address issued alongside stage 1
            color_q       <= visible_q ? mem_data : 5'd31;
            hsync_q       <= hsync_raw_q;
            vsync_q       <= vsync_raw_q;
            de_q          <= visible_q;
            frame_start_q <= first_pixel_q;
        end
    end

    assign color       = color_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - self-checking bench for vga_pixel_fetch
module tb_vga_pixel_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance
    logic        rst_n = 1'b0, ce = 1'b0;
    logic [10:0] mem_addr;
    logic [4:0]  mem_data = 5'd0, color;
    logic        hsync, vsync, de, frame_start;

    // Reduced-timing instance for whole-frame behaviour
    logic        rst_n_s = 1'b0, ce_s = 1'b0;
    logic [10:0] mem_addr_s;
    logic [4:0]  mem_data_s = 5'd0, color_s;
    logic        hsync_s, vsync_s, de_s, frame_start_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    vga_pixel_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .mem_addr(mem_addr), .mem_data(mem_data),
        .color(color), .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    vga_pixel_fetch #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .CELL_SHIFT(2), .ADDR_W(11)
    ) u_small (
        .clk(clk), .rst_n(rst_n_s), .ce(ce_s), .mem_addr(mem_addr_s), .mem_data(mem_data_s),
        .color(color_s), .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .frame_start(frame_start_s)
    );

    // Synchronous RAM models: index = low 5 address bits, one enabled cycle latency
    always @(posedge clk) if (ce) mem_data <= mem_addr[4:0];
    always @(posedge clk) if (ce_s) mem_data_s <= mem_addr_s[4:0];

    // Expected {color, de, hsync, vsync, frame_start} after n enabled edges since reset release
    function automatic logic [8:0] exp_out(input int n, input int hv, input int hf, input int hsw,
                                           input int hb, input int vv, input int vf, input int vsw,
                                           input int vb, input int cs);
        int p, x, y, ht, vt, a;
        logic vis, hs, vs, fs;
        logic [4:0] col;
        if (n < 2) return {5'd31, 1'b0, 1'b1, 1'b1, 1'b0};
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p = (n - 2) % (ht * vt);
        x = p % ht;
        y = p / ht;
        vis = (x < hv) && (y < vv);
        a = vis ? ((y >> cs) * (hv >> cs) + (x >> cs)) : 0;
        col = vis ? a[4:0] : 5'd31;
        hs = !((x >= hv + hf) && (x < hv + hf + hsw));
        vs = !((y >= vv + vf) && (y < vv + vf + vsw));
        fs = (x == 0) && (y == 0);
        return {col, vis, hs, vs, fs};
    endfunction

    // Expected mem_addr while the counters sit on pixel p
    function automatic int exp_addr(input int p, input int hv, input int hf, input int hsw,
                                    input int hb, input int vv, input int vf, input int vsw,
                                    input int vb, input int cs);
        int x, y, ht, vt, q;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        q = p % (ht * vt);
        x = q % ht;
        y = q / ht;
        if ((x < hv) && (y < vv)) return (y >> cs) * (hv >> cs) + (x >> cs);
        return 0;
    endfunction

    function automatic logic [8:0] main_out(input int n);
        return exp_out(n, 640, 16, 96, 48, 480, 10, 2, 33, 4);
    endfunction
    function automatic int main_addr(input int p);
        return exp_addr(p, 640, 16, 96, 48, 480, 10, 2, 33, 4);
    endfunction
    function automatic logic [8:0] small_out(input int n);
        return exp_out(n, 16, 2, 3, 3, 8, 1, 2, 2, 2);
    endfunction
    function automatic int small_addr(input int p);
        return exp_addr(p, 16, 2, 3, 3, 8, 1, 2, 2, 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_main();
        rst_n = 1'b0;
        ce = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b1;
        repeat (3) step();
        total_cnt++; if (color !== 5'd31) $display("FAIL reset_color: got %0d expected 31", color); else pass_cnt++;
        total_cnt++; if (hsync !== 1'b1) $display("FAIL reset_hsync: got %b expected 1", hsync); else pass_cnt++;
        total_cnt++; if (vsync !== 1'b1) $display("FAIL reset_vsync: got %b expected 1", vsync); else pass_cnt++;
        total_cnt++; if (de !== 1'b0) $display("FAIL reset_de: got %b expected 0", de); else pass_cnt++;
        total_cnt++; if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b expected 0", frame_start); else pass_cnt++;
        total_cnt++; if (mem_addr !== 11'd0) $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (mem_addr !== 11'd0) $display("FAIL release_mem_addr: got %0d expected 0", mem_addr); else pass_cnt++;
    endtask

    task automatic test_line_timing();
        int errs = 0, aerrs = 0, de_rise0 = -1, de_rise1 = -1, hs_fall = -1, hs_len = 0;
        int de_cnt = 0, vs_low = 0, fs_cnt = 0, fs_at2 = 0;
        logic prev_de = 1'b0;
        reset_main();
        for (int n = 1; n <= 1800; n++) begin
            step();
            if ({color, de, hsync, vsync, frame_start} !== main_out(n)) errs++;
            if (int'(mem_addr) != main_addr(n)) aerrs++;
            if (de && !prev_de) begin
                if (de_rise0 < 0) de_rise0 = n;
                else if (de_rise1 < 0) de_rise1 = n;
            end
            prev_de = de;
            if (n <= 800 && de) de_cnt++;
            if (!hsync && hs_fall < 0) hs_fall = n;
            if (!hsync && n <= 800) hs_len++;
            if (!vsync) vs_low++;
            if (frame_start) fs_cnt++;
            if (n == 2) fs_at2 = frame_start;
        end
        total_cnt++; if (de_rise0 !== 2) $display("FAIL de_rise: got %0d expected 2", de_rise0); else pass_cnt++;
        total_cnt++; if (de_cnt !== 640) $display("FAIL de_width: got %0d expected 640", de_cnt); else pass_cnt++;
        total_cnt++; if (hs_fall - de_rise0 !== 656) $display("FAIL hsync_offset: got %0d expected 656", hs_fall - de_rise0); else pass_cnt++;
        total_cnt++; if (hs_len !== 96) $display("FAIL hsync_width: got %0d expected 96", hs_len); else pass_cnt++;
        total_cnt++; if (de_rise1 - de_rise0 !== 800) $display("FAIL line_period: got %0d expected 800", de_rise1 - de_rise0); else pass_cnt++;
        total_cnt++; if (errs !== 0) $display("FAIL line_outputs: got %0d bad cycles expected 0", errs); else pass_cnt++;
        total_cnt++; if (aerrs !== 0) $display("FAIL line_addr: got %0d bad cycles expected 0", aerrs); else pass_cnt++;
        total_cnt++; if (vs_low !== 0) $display("FAIL line_vsync: got %0d low cycles expected 0", vs_low); else pass_cnt++;
        total_cnt++; if (fs_cnt !== 1 || fs_at2 !== 1) $display("FAIL line_frame_start: got count %0d at2 %0d expected 1 1", fs_cnt, fs_at2); else pass_cnt++;
    endtask

    task automatic test_address_map();
        reset_main();
        for (int n = 1; n <= 27042; n++) begin
            step();
            if (n == 26417) begin
                total_cnt++; if (mem_addr !== 11'd81) $display("FAIL addr_17_33: got %0d expected 81", mem_addr); else pass_cnt++;
            end
            if (n == 26419) begin
                total_cnt++; if (color !== 5'd17 || de !== 1'b1) $display("FAIL color_17_33: got %0d de %b expected 17 de 1", color, de); else pass_cnt++;
            end
            if (n == 27039) begin
                total_cnt++; if (mem_addr !== 11'd119) $display("FAIL addr_639_33: got %0d expected 119", mem_addr); else pass_cnt++;
            end
            if (n == 27040) begin
                total_cnt++; if (mem_addr !== 11'd0) $display("FAIL addr_640_33: got %0d expected 0", mem_addr); else pass_cnt++;
            end
            if (n == 27042) begin
                total_cnt++; if (color !== 5'd31 || de !== 1'b0) $display("FAIL color_640_33: got %0d de %b expected 31 de 0", color, de); else pass_cnt++;
            end
        end
    endtask

    task automatic test_clock_enable();
        int m = 0, errs = 0, aerrs = 0, moved = 0;
        logic [8:0] prev, cur;
        reset_main();
        prev = {color, de, hsync, vsync, frame_start};
        for (int i = 0; i < 2000; i++) begin
            ce = (i % 2 == 1);
            step();
            if (ce) m++;
            cur = {color, de, hsync, vsync, frame_start};
            if (cur !== main_out(m)) errs++;
            if (int'(mem_addr) != main_addr(m)) aerrs++;
            if (!ce && cur !== prev) moved++;
            prev = cur;
        end
        ce = 1'b1;
        total_cnt++; if (errs !== 0) $display("FAIL ce_outputs: got %0d bad cycles expected 0", errs); else pass_cnt++;
        total_cnt++; if (aerrs !== 0) $display("FAIL ce_addr: got %0d bad cycles expected 0", aerrs); else pass_cnt++;
        total_cnt++; if (moved !== 0) $display("FAIL ce_hold: got %0d changes without ce expected 0", moved); else pass_cnt++;
    endtask

    task automatic test_mid_frame_reset();
        int errs = 0;
        reset_main();
        for (int n = 1; n <= 1900; n++) step();
        rst_n = 1'b0;
        ce = 1'b0;
        step();
        total_cnt++; if ({color, de, hsync, vsync, frame_start} !== {5'd31, 1'b0, 1'b1, 1'b1, 1'b0})
            $display("FAIL midreset_outputs: got %h expected %h", {color, de, hsync, vsync, frame_start}, {5'd31, 1'b0, 1'b1, 1'b1, 1'b0});
        else pass_cnt++;
        total_cnt++; if (mem_addr !== 11'd0) $display("FAIL midreset_addr: got %0d expected 0", mem_addr); else pass_cnt++;
        rst_n = 1'b1;
        ce = 1'b1;
        for (int n = 1; n <= 810; n++) begin
            step();
            if ({color, de, hsync, vsync, frame_start} !== main_out(n)) errs++;
            if (n == 2) begin
                total_cnt++; if (frame_start !== 1'b1) $display("FAIL midreset_restart: got %b expected 1", frame_start); else pass_cnt++;
            end
        end
        total_cnt++; if (errs !== 0) $display("FAIL midreset_line: got %0d bad cycles expected 0", errs); else pass_cnt++;
    endtask

    task automatic test_small_frames();
        int errs = 0, aerrs = 0, de_cnt = 0, vs_low = 0, hs_falls = 0, fs_cnt = 0;
        logic prev_hs = 1'b1;
        rst_n_s = 1'b0;
        ce_s = 1'b1;
        repeat (2) step();
        rst_n_s = 1'b1;
        for (int n = 1; n <= 940; n++) begin
            step();
            if ({color_s, de_s, hsync_s, vsync_s, frame_start_s} !== small_out(n)) errs++;
            if (int'(mem_addr_s) != small_addr(n)) aerrs++;
            if (n >= 2 && n < 314) begin
                if (de_s) de_cnt++;
                if (!vsync_s) vs_low++;
                if (prev_hs && !hsync_s) hs_falls++;
            end
            prev_hs = hsync_s;
            if (frame_start_s) fs_cnt++;
            if (n == 183) begin
                total_cnt++; if (mem_addr_s !== 11'd7) $display("FAIL small_addr_corner: got %0d expected 7", mem_addr_s); else pass_cnt++;
            end
            if (n == 312) begin
                total_cnt++; if (mem_addr_s !== 11'd0) $display("FAIL small_addr_wrap: got %0d expected 0", mem_addr_s); else pass_cnt++;
            end
        end
        total_cnt++; if (errs !== 0) $display("FAIL small_outputs: got %0d bad cycles expected 0", errs); else pass_cnt++;
        total_cnt++; if (aerrs !== 0) $display("FAIL small_addr: got %0d bad cycles expected 0", aerrs); else pass_cnt++;
        total_cnt++; if (de_cnt !== 128) $display("FAIL small_de_count: got %0d expected 128", de_cnt); else pass_cnt++;
        total_cnt++; if (vs_low !== 48) $display("FAIL small_vsync_low: got %0d expected 48", vs_low); else pass_cnt++;
        total_cnt++; if (hs_falls !== 13) $display("FAIL small_hsync_pulses: got %0d expected 13", hs_falls); else pass_cnt++;
        total_cnt++; if (fs_cnt !== 4) $display("FAIL small_frame_start: got %0d expected 4", fs_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_address_map();
        test_clock_enable();
        test_mid_frame_reset();
        test_small_frames();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
